// File: rtl/mul_share_scheduler_if.sv
// Request/result bundle between the ALU issue slots, the shared-multiplier
// scheduler and the single multiplier instance.
interface mul_share_scheduler_if #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [N-1:0]      mul_z;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_z;
  logic [IDW-1:0]    res_id;
  logic              busy;

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, mul_z, res_ready,
    output req_ready, mul_a, mul_b, res_valid, res_z, res_id, busy
  );

  // Requesters, result consumer and multiplier side
  modport master (
    output req_valid, req_a, req_b, mul_z, res_ready,
    input  req_ready, mul_a, mul_b, res_valid, res_z, res_id, busy
  );
endinterface

// File: rtl/mul_share_scheduler.sv
// Round-robin time-sharing of one combinational N-bit multiplier between
// NREQ requesters. Operands are registered and the product is sampled
// MUL_WAIT cycles later, so the multiplier is a multicycle path.
module mul_share_scheduler #(
  parameter int N        = 32,
  parameter int NREQ     = 4,
  parameter int MUL_WAIT = 3,
  parameter int IDW      = $clog2(NREQ)
) (
  input logic clk,
  input logic reset,
  mul_share_scheduler_if.slave bus
);

  localparam int CW = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [IDW-1:0]           last_grant;
  logic [N-1:0]             mul_a, mul_b, res_z;
  logic [IDW-1:0]           res_id;
  logic                     res_valid;
  logic                     gnt_found;
  logic [IDW-1:0]           gnt_idx;
  logic [NREQ-1:0][N-1:0]   a_vec, b_vec;

  assign a_vec = bus.req_a;
  assign b_vec = bus.req_b;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (!gnt_found && bus.req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  // One-hot accept strobe, only while idle
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Scheduler FSM: grant, let the multiplier settle, hold result until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDW'(NREQ - 1);
      mul_a      <= '0;
      mul_b      <= '0;
      res_z      <= '0;
      res_id     <= '0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mul_a      <= a_vec[gnt_idx];
            mul_b      <= b_vec[gnt_idx];
            res_id     <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= CW'(MUL_WAIT - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            res_z     <= bus.mul_z;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_a     = mul_a;
  assign bus.mul_b     = mul_b;
  assign bus.res_z     = res_z;
  assign bus.res_id    = res_id;
  assign bus.res_valid = res_valid;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_share_scheduler.sv
// Scoreboard bench for mul_share_scheduler (N=8, NREQ=4, MUL_WAIT=2).
// The multiplier model registers its product once, so a result sampled too
// early would be stale.
module tb_mul_share_scheduler;
  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int MW   = 2;

  typedef struct {
    logic [1:0] id;
    logic [7:0] z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_share_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

  mul_share_scheduler #(.N(N), .NREQ(NREQ), .MUL_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [NREQ-1:0][N-1:0] a_in, b_in;
  logic [N-1:0]           zreg;
  assign bus.req_a = a_in;
  assign bus.req_b = b_in;

  // Multiplier model: product becomes valid one cycle after operands change
  always @(posedge clk) zreg <= N'(bus.mul_a * bus.mul_b);
  assign bus.mul_z = zreg;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result id=%0d z=%0h expected none", bus.res_id, bus.res_z);
      end else begin
        mon_e = q.pop_front();
        chk("res_id", 32'(bus.res_id), 32'(mon_e.id));
        chk("res_z", 32'(bus.res_z), 32'(mon_e.z));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        seen = 1'b1;
        chk("ready_onehot", 32'(bus.req_ready), 32'(1) << k);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=none expected=req %0d", k);
    end
  endtask

  task automatic wait_idle;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (!bus.busy) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic wait_rv;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL res_valid_timeout actual=0 expected=1");
    end
  endtask

  task automatic single(input int k, input logic [7:0] a, input logic [7:0] b);
    a_in[k] = a;
    b_in[k] = b;
    bus.req_valid[k] = 1'b1;
    wait_ready(k);
    step();
    bus.req_valid[k] = 1'b0;
    wait_idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int last;
    int ng;
    order = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    a_in = '0;
    b_in = '0;

    // Reset state
    @(negedge clk);
    chk("rst_mul_a", 32'(bus.mul_a), 0);
    chk("rst_mul_b", 32'(bus.mul_b), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_z", 32'(bus.res_z), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    step();
    reset = 1'b0;

    // Requester 1: 13*11 = 0x8F, result at T+3, idle at T+4
    a_in[1] = 8'd13;
    b_in[1] = 8'd11;
    bus.req_valid = 4'b0010;
    q.push_back('{2'd1, 8'h8F});
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_rv_t1", 32'(bus.res_valid), 0);
    step();
    @(negedge clk);
    chk("t1_rv_t2", 32'(bus.res_valid), 0);
    step();
    @(negedge clk);
    chk("t1_rv_t3", 32'(bus.res_valid), 1);
    step();
    @(negedge clk);
    chk("t1_idle_t4", 32'(bus.busy), 0);
    step();

    // All four valid: grants 0,1,2,3,0 spaced exactly 4 cycles
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      a_in[k] = 8'(k + 2);
      b_in[k] = 8'(k + 3);
    end
    q.push_back('{2'd0, 8'h06});
    q.push_back('{2'd1, 8'h0C});
    q.push_back('{2'd2, 8'h14});
    q.push_back('{2'd3, 8'h1E});
    q.push_back('{2'd0, 8'h06});
    bus.req_valid = 4'b1111;
    last = 0;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        chk("t2_order", 32'(bus.req_ready), 32'(1) << order[ng]);
        if (ng > 0) chk("t2_gap", 32'(c - last), 4);
        last = c;
        ng++;
      end
    end
    if (ng < 5) begin
      checks++;
      errors++;
      $display("FAIL t2_grants actual=%0d expected=5", ng);
    end
    step();
    bus.req_valid = '0;
    wait_idle();
    step();

    // Truncation: 255*255 -> 0x01, 20*15 -> 0x2C
    q.push_back('{2'd3, 8'h01});
    single(3, 8'd255, 8'd255);
    q.push_back('{2'd0, 8'h2C});
    single(0, 8'd20, 8'd15);

    // Backpressure: result held, requester 2 stalled then granted
    bus.res_ready = 1'b0;
    q.push_back('{2'd1, 8'h3F});
    q.push_back('{2'd2, 8'h2A});
    a_in[1] = 8'd7;
    b_in[1] = 8'd9;
    bus.req_valid[1] = 1'b1;
    wait_ready(1);
    step();
    bus.req_valid[1] = 1'b0;
    wait_rv();
    a_in[2] = 8'd6;
    b_in[2] = 8'd7;
    bus.req_valid[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_rv", 32'(bus.res_valid), 1);
      chk("t4_hold_z", 32'(bus.res_z), 32'h3F);
      chk("t4_hold_id", 32'(bus.res_id), 1);
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    step();
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t4_done_ready", 32'(bus.req_ready), 0);
    step();
    @(negedge clk);
    chk("t4_grant2", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = '0;
    wait_idle();
    step();

    // Reset during the second WAIT cycle discards the operation
    a_in[1] = 8'd9;
    b_in[1] = 8'd9;
    bus.req_valid[1] = 1'b1;
    wait_ready(1);
    step();
    bus.req_valid[1] = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("t5_mul_a", 32'(bus.mul_a), 0);
    chk("t5_mul_b", 32'(bus.mul_b), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_res_valid", 32'(bus.res_valid), 0);
    chk("t5_res_id", 32'(bus.res_id), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rv_after", 32'(bus.res_valid), 0);
    step();
    a_in[0] = 8'd3;
    b_in[0] = 8'd5;
    a_in[2] = 8'd4;
    b_in[2] = 8'd4;
    bus.req_valid = 4'b0101;
    q.push_back('{2'd0, 8'h0F});
    @(negedge clk);
    chk("t5_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    wait_idle();
    step();

    // Requester 2 valid for one cycle while 0 wins, then drops
    do_reset();
    a_in[0] = 8'd6;
    b_in[0] = 8'd6;
    a_in[2] = 8'd2;
    b_in[2] = 8'd9;
    bus.req_valid = 4'b0101;
    q.push_back('{2'd0, 8'h24});
    @(negedge clk);
    chk("t6_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t6_no_grant", 32'(bus.req_ready), 0);
    end

    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_share_scheduler.md
Name: mul_share_scheduler

Overview:
- Time-shares one combinational N-bit array multiplier (truncated product, Z = low N bits of A*B) between NREQ requesters.
- Round-robin arbitration on a valid/ready request interface; registered operands drive the multiplier.
- The multiplier's deep carry-save ripple is treated as a multicycle path: the product is sampled MUL_WAIT cycles after operands are launched.
- Sits between client datapaths (ALU issue slots) and the single multiplier instance.

Parameters:
- N, 32, operand and result width; must match the attached multiplier.
- NREQ, 4, number of requesters; must be 2 or more.
- MUL_WAIT, 3, cycles allowed for the multiplier to settle; must be 1 or more.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*N  packed A operands; requester k uses bits [k*N +: N]
- req_b  in  NREQ*N  packed B operands, same packing as req_a
- req_ready  out  NREQ  one-hot accept strobe, combinational
- mul_a  out  N  registered A to the multiplier
- mul_b  out  N  registered B to the multiplier
- mul_z  in  N  multiplier product (combinational from mul_a/mul_b)
- res_valid  out  1  result available
- res_ready  in  1  result consumer accepts
- res_z  out  N  registered product
- res_id  out  IDW  requester index owning res_z
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - state = IDLE
  - mul_a = mul_b = 0, res_z = 0, res_id = 0, res_valid = 0, busy = 0
  - wait counter = 0
  - rr pointer last_grant = NREQ-1, so requester 0 has highest priority first
- States: IDLE, WAIT, DONE.
- IDLE:
  - Round-robin search starts at (last_grant+1) mod NREQ and wraps; the first k with req_valid[k]=1 wins.
  - req_ready[k] = 1 combinationally that cycle; all other bits are 0. This is the handshake.
  - On the clock edge:
    - mul_a <= req_a[k], mul_b <= req_b[k], res_id <= k, last_grant <= k
    - counter <= MUL_WAIT-1
    - state -> WAIT
  - With no valid request: stay in IDLE, req_ready = 0.
- WAIT:
  - req_ready = 0 and mul_a/mul_b are held stable.
  - Counter decrements each cycle.
  - When the counter is 0: res_z <= mul_z, res_valid <= 1, state -> DONE.
  - WAIT therefore lasts exactly MUL_WAIT cycles.
- DONE:
  - res_valid = 1; res_z and res_id are held.
  - When res_ready = 1: res_valid <= 0 and state -> IDLE.
  - req_ready stays 0 in DONE, so a new grant happens in the following IDLE cycle at the earliest.
- Latency:
  - Accept at cycle T. res_valid is high from T+MUL_WAIT+1.
  - Minimum issue interval is MUL_WAIT+2 cycles when res_ready is tied high.
- Arithmetic:
  - No width growth; the overflow high half is discarded (e.g. N=8: 255*255 -> 0x01).
  - Operands are unsigned bit patterns; two's-complement low half is identical.
- Boundary conditions:
  - Requester drops req_valid before being granted: legal, the request is not taken.
  - Requester must hold req_a/req_b stable only while req_valid=1 and req_ready=0.
  - Only a single requester valid: it is granted every round regardless of last_grant.
  - res_ready high while in IDLE/WAIT: ignored.
  - Reset asserted in WAIT or DONE: the in-flight operation is discarded, no res_valid pulse, and the pointer returns to NREQ-1.
  - MUL_WAIT=1: WAIT lasts one cycle.
  - res_ready held low indefinitely: DONE holds and all requesters are stalled (no request dropped).

Test Plan:
- N=8, NREQ=4, MUL_WAIT=2; requester 1 sends A=13, B=11 at T -> req_ready=0010 at T; res_valid rises T+3 with res_z=0x8F, res_id=1; res_ready=1 returns state to IDLE at T+4.
- All four req_valid held high, res_ready tied 1 -> grant order 0,1,2,3,0, with consecutive req_ready pulses exactly 4 cycles apart.
- Requester 3 sends 255*255 -> res_z=0x01; requester 0 sends 20*15 -> res_z=0x2C.
- Hold res_ready=0 for 10 cycles after res_valid -> res_valid, res_z and res_id stay constant; req_ready=0 throughout; a pending requester 2 is granted the cycle after res_ready goes high and the state reaches IDLE.
- Reset pulsed during the second WAIT cycle -> all outputs return to 0 asynchronously, no res_valid; next grant with 0 and 2 valid goes to 0.
- Requester 2 asserts valid for one cycle while requester 0 is granted, then drops -> requester 2 is never granted, and no result carries res_id=2.
